// File: rtl/qpmm_sched.sv
// qpmm_sched: arbitrates requesters onto a limb-serial modular multiplier and routes results back.
// Optional perf counters are compiled in with QPMM_SCHED_PERF_EN.
module qpmm_sched #(
    parameter int NREQ = 2,
    parameter int K    = 16,
    parameter int N    = 17,
    parameter int W    = K * N,
    parameter int TQD  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_i,
    output logic              mm_start_o,
    output logic              mm_limb_valid_o,
    output logic [K-1:0]      mm_b_limb_o,
    output logic [W-1:0]      mm_a_o,
    input  logic              mm_res_valid_i,
    input  logic [W-1:0]      mm_res_i,
    output logic [NREQ-1:0]   rsp_valid_o,
    input  logic [NREQ-1:0]   rsp_ready_i,
    output logic [NREQ*W-1:0] rsp_data_o,
    output logic              err_o
`ifdef QPMM_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_ops_o,
    output logic [31:0]       perf_feed_o
`endif
);
    localparam int TW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int QW = (TQD > 1) ? $clog2(TQD) : 1;
    localparam int NW = $clog2(TQD + 1);

    typedef enum logic {IDLE, FEED} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [TW-1:0]   ptr;
    logic [NREQ-1:0] busy;
    logic [W-1:0]    b_sh;
    logic [TW-1:0]   tq [TQD];
    logic [QW-1:0]   tq_wr;
    logic [QW-1:0]   tq_rd;
    logic [NW-1:0]   tq_cnt;

    logic [NREQ-1:0] elig;
    logic [TW-1:0]   win;
    logic [TW-1:0]   tag;
    logic            any_elig;
    logic            slot;
    logic            accept;
    logic            pop;

    function automatic logic [QW-1:0] qinc(input logic [QW-1:0] v);
        return (v == QW'(TQD - 1)) ? '0 : v + 1'b1;
    endfunction

    assign elig   = req_valid_i & ~busy;
    assign slot   = (state == IDLE) ||
                    (state == FEED && cnt == CW'(N - 1));
    assign accept = !rst && slot && any_elig &&
                    (tq_cnt != NW'(TQD));
    assign pop    = mm_res_valid_i && (tq_cnt != '0);
    assign tag    = tq[tq_rd];

    // Round-robin: walk downward so the lowest offset from ptr wins.
    always_comb begin
        win      = '0;
        any_elig = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (elig[(int'(ptr) + k) % NREQ]) begin
                win      = TW'((int'(ptr) + k) % NREQ);
                any_elig = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (accept)
            req_ready_o[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            ptr             <= '0;
            busy            <= '0;
            b_sh            <= '0;
            tq_wr           <= '0;
            tq_rd           <= '0;
            tq_cnt          <= '0;
            mm_start_o      <= 1'b0;
            mm_limb_valid_o <= 1'b0;
            mm_b_limb_o     <= '0;
            mm_a_o          <= '0;
            rsp_valid_o     <= '0;
            rsp_data_o      <= '0;
            err_o           <= 1'b0;
        end else begin
            busy <= busy & ~(rsp_valid_o & rsp_ready_i);
            rsp_valid_o <= rsp_valid_o & ~rsp_ready_i;

            if (accept) begin
                busy[win]       <= 1'b1;
                tq[tq_wr]       <= win;
                tq_wr           <= qinc(tq_wr);
                state           <= FEED;
                cnt             <= '0;
                mm_a_o          <= req_a_i[int'(win)*W +: W];
                mm_b_limb_o     <= req_b_i[int'(win)*W +: K];
                b_sh            <= req_b_i[int'(win)*W +: W] >> K;
                mm_start_o      <= 1'b1;
                mm_limb_valid_o <= 1'b1;
                ptr <= (win == TW'(NREQ - 1)) ? '0 : win + 1'b1;
            end else if (state == FEED) begin
                mm_start_o <= 1'b0;
                if (cnt == CW'(N - 1)) begin
                    state           <= IDLE;
                    cnt             <= '0;
                    mm_limb_valid_o <= 1'b0;
                    mm_b_limb_o     <= '0;
                end else begin
                    cnt         <= cnt + 1'b1;
                    mm_b_limb_o <= b_sh[K-1:0];
                    b_sh        <= b_sh >> K;
                end
            end

            // Results return in issue order, so the queue head names the owner.
            if (pop) begin
                tq_rd                        <= qinc(tq_rd);
                rsp_valid_o[tag]             <= 1'b1;
                rsp_data_o[int'(tag)*W +: W] <= mm_res_i;
            end
            if (mm_res_valid_i && tq_cnt == '0)
                err_o <= 1'b1;

            if (accept && !pop)
                tq_cnt <= tq_cnt + 1'b1;
            else if (pop && !accept)
                tq_cnt <= tq_cnt - 1'b1;
        end
    end

`ifdef QPMM_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops_o  <= '0;
            perf_feed_o <= '0;
        end else begin
            if (accept)
                perf_ops_o <= perf_ops_o + 1'b1;
            if (mm_limb_valid_o)
                perf_feed_o <= perf_feed_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_qpmm_sched.sv
// tb_qpmm_sched: directed bench for qpmm_sched with a delayed a*b multiplier model.
// Drives inputs just after the rising edge and samples on the falling edge.
module tb_qpmm_sched;
    localparam int NREQ = 2;
    localparam int K    = 16;
    localparam int N    = 17;
    localparam int W    = K * N;
    localparam int TQD  = 4;
    localparam int CW   = NREQ * W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] req_valid_i = '0;
    logic [NREQ-1:0] req_ready_o;
    logic [CW-1:0]   req_a_i = '0;
    logic [CW-1:0]   req_b_i = '0;
    logic            mm_start_o;
    logic            mm_limb_valid_o;
    logic [K-1:0]    mm_b_limb_o;
    logic [W-1:0]    mm_a_o;
    logic            mm_res_valid_i;
    logic [W-1:0]    mm_res_i;
    logic [NREQ-1:0] rsp_valid_o;
    logic [NREQ-1:0] rsp_ready_i = '0;
    logic [CW-1:0]   rsp_data_o;
    logic            err_o;
`ifdef QPMM_SCHED_PERF_EN
    logic [31:0]     perf_ops_o;
    logic [31:0]     perf_feed_o;
`endif

    qpmm_sched #(
        .NREQ(NREQ), .K(K), .N(N), .W(W), .TQD(TQD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_a_i        (req_a_i),
        .req_b_i        (req_b_i),
        .mm_start_o     (mm_start_o),
        .mm_limb_valid_o(mm_limb_valid_o),
        .mm_b_limb_o    (mm_b_limb_o),
        .mm_a_o         (mm_a_o),
        .mm_res_valid_i (mm_res_valid_i),
        .mm_res_i       (mm_res_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_ready_i    (rsp_ready_i),
        .rsp_data_o     (rsp_data_o),
        .err_o          (err_o)
`ifdef QPMM_SCHED_PERF_EN
        ,
        .perf_ops_o     (perf_ops_o),
        .perf_feed_o    (perf_feed_o)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int g0 = 0;

    always @(negedge clk)
        if (req_ready_o[0])
            g0++;

    // Multiplier model: result a*b mod 2^W, 20 cycles after the last limb.
    int            cyc = 0;
    int            nlimb = 0;
    logic [W-1:0]  acc_a;
    logic [W-1:0]  acc_b;
    int            due_q[$];
    logic [W-1:0]  res_q[$];

    initial begin
        mm_res_valid_i = 1'b0;
        mm_res_i = '0;
        acc_a = '0;
        acc_b = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            mm_res_valid_i = 1'b0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                void'(due_q.pop_front());
                mm_res_i = res_q.pop_front();
                mm_res_valid_i = 1'b1;
            end
            @(negedge clk);
            if (mm_limb_valid_o) begin
                if (mm_start_o) begin
                    acc_a = mm_a_o;
                    acc_b = '0;
                    nlimb = 0;
                end
                if (nlimb < N) begin
                    acc_b[nlimb*K +: K] = mm_b_limb_o;
                    nlimb++;
                    if (nlimb == N) begin
                        due_q.push_back(cyc + 20);
                        res_q.push_back(acc_a * acc_b);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [CW-1:0] act,
                       input logic [CW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        next();
        rst = 1'b1;
        req_valid_i = '0;
        rsp_ready_i = '0;
        next();
        next();
        rst = 1'b0;
    endtask

    task automatic set_op(input int r, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        req_a_i[r*W +: W] = a;
        req_b_i[r*W +: W] = b;
    endtask

    task automatic wait_rsp(input int r, input string nm);
        bit ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            mid();
            ok = rsp_valid_o[r];
            if (!ok)
                next();
        end
        chk({nm, " rsp seen"}, CW'(ok), 1);
    endtask

    task automatic ack_rsp(input int r, input string nm);
        next();
        rsp_ready_i[r] = 1'b1;
        mid();
        next();
        rsp_ready_i[r] = 1'b0;
        mid();
        chk({nm, " rsp clear"}, CW'(rsp_valid_o[r]), 0);
    endtask

    task automatic do_op(input int r, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] e,
                         input string nm);
        bit ok = 0;
        next();
        set_op(r, a, b);
        req_valid_i[r] = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            mid();
            ok = req_ready_o[r];
            next();
        end
        req_valid_i[r] = 1'b0;
        chk({nm, " grant"}, CW'(ok), 1);
        wait_rsp(r, nm);
        chk({nm, " data"}, CW'(rsp_data_o[r*W +: W]), CW'(e));
        ack_rsp(r, nm);
    endtask

    typedef struct {
        int           r;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] e;
    } vec_t;

    vec_t vt[7];

    initial begin
        logic [W-1:0] ones;
        logic [K-1:0] lexp;
        int nv, lastv, r1c, g0s;
        bit any_rsp, got;

        ones = '1;
        vt[0] = '{0, 272'd5, 272'h10007, 272'h50023};
        vt[1] = '{1, 272'd3, 272'd7, 272'h15};
        vt[2] = '{0, 272'hFFFF, 272'hFFFF, 272'hFFFE0001};
        vt[3] = '{1, 272'd1 << 271, 272'd2, 272'd0};
        vt[4] = '{0, (272'd1 << 200) | 272'd1, 272'd3,
                  (272'd3 << 200) | 272'd3};
        vt[5] = '{1, 272'h1234, 272'd1 << 256, 272'h1234 << 256};
        vt[6] = '{0, ones, ones, 272'd1};

        do_reset();
        mid();
        chk("rst req_ready", CW'(req_ready_o), 0);
        chk("rst mm_start", CW'(mm_start_o), 0);
        chk("rst limb_valid", CW'(mm_limb_valid_o), 0);
        chk("rst b_limb", CW'(mm_b_limb_o), 0);
        chk("rst mm_a", CW'(mm_a_o), 0);
        chk("rst rsp_valid", CW'(rsp_valid_o), 0);
        chk("rst rsp_data", rsp_data_o, 0);
        chk("rst err", CW'(err_o), 0);

        // Single operation: limb order, start marker, result routing.
        next();
        set_op(0, 272'd5, 272'h10007);
        req_valid_i = 2'b01;
        mid();
        chk("op1 ready", CW'(req_ready_o), 2'b01);
        for (int k = 0; k < N; k++) begin
            next();
            req_valid_i = '0;
            mid();
            lexp = (k == 0) ? 16'h0007 : (k == 1) ? 16'h0001 : 16'h0000;
            chk($sformatf("op1 valid l%0d", k), CW'(mm_limb_valid_o), 1);
            chk($sformatf("op1 start l%0d", k), CW'(mm_start_o), CW'(k == 0));
            chk($sformatf("op1 limb l%0d", k), CW'(mm_b_limb_o), CW'(lexp));
            chk($sformatf("op1 a l%0d", k), CW'(mm_a_o), 5);
        end
        next();
        mid();
        chk("op1 feed end", CW'(mm_limb_valid_o), 0);
        wait_rsp(0, "op1");
        chk("op1 data", CW'(rsp_data_o[0 +: W]), 272'h50023);
        chk("op1 only r0", CW'(rsp_valid_o), 2'b01);
        ack_rsp(0, "op1");

        // Two requesters together: back-to-back feed with no bubble.
        do_reset();
        next();
        set_op(0, 272'd2, 272'd3);
        set_op(1, 272'd4, 272'd5);
        req_valid_i = 2'b11;
        mid();
        chk("b2b first grant", CW'(req_ready_o), 2'b01);
        nv = 0;
        lastv = -1;
        r1c = -1;
        for (int c = 1; c <= 40; c++) begin
            next();
            if (c == 1)
                req_valid_i[0] = 1'b0;
            if (r1c > 0 && c == r1c + 1)
                req_valid_i[1] = 1'b0;
            mid();
            if (req_ready_o[1] && r1c < 0)
                r1c = c;
            if (mm_limb_valid_o) begin
                nv++;
                lastv = c;
            end
            if (c == 18)
                chk("b2b op2 start", CW'(mm_start_o), 1);
        end
        chk("b2b r1 grant cycle", CW'(r1c), 17);
        chk("b2b limb count", CW'(nv), 34);
        chk("b2b last limb", CW'(lastv), 34);
        got = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            mid();
            got = (rsp_valid_o == 2'b11);
            if (!got)
                next();
        end
        chk("b2b both rsp", CW'(got), 1);
        chk("b2b r0 data", CW'(rsp_data_o[0 +: W]), 6);
        chk("b2b r1 data", CW'(rsp_data_o[W +: W]), 20);
        next();
        rsp_ready_i = 2'b11;
        next();
        rsp_ready_i = 2'b00;
        mid();
        chk("b2b rsp clear", CW'(rsp_valid_o), 0);

        // Unconsumed response blocks re-grant; release re-grants next cycle.
        do_reset();
        next();
        set_op(0, 272'd1, 272'd1);
        req_valid_i = 2'b01;
        mid();
        chk("hold r0 grant", CW'(req_ready_o), 2'b01);
        wait_rsp(0, "hold r0");
        next();
        g0s = g0;
        do_op(1, 272'd3, 272'd5, 272'd15, "hold r1a");
        do_op(1, 272'd6, 272'd7, 272'd42, "hold r1b");
        next();
        chk("hold r0 no regrant", CW'(g0), CW'(g0s));
        rsp_ready_i[0] = 1'b1;
        mid();
        chk("hold same-cycle", CW'(req_ready_o[0]), 0);
        next();
        rsp_ready_i[0] = 1'b0;
        mid();
        chk("hold regrant", CW'(req_ready_o[0]), 1);
        next();
        req_valid_i[0] = 1'b0;
        wait_rsp(0, "hold r0b");
        chk("hold r0b data", CW'(rsp_data_o[0 +: W]), 1);
        ack_rsp(0, "hold r0b");

        // Reset during feed of the second op; first op's result lands late.
        do_reset();
        next();
        set_op(0, 272'd7, 272'd9);
        set_op(1, 272'd3, 272'd3);
        req_valid_i = 2'b11;
        mid();
        for (int c = 1; c <= 25; c++) begin
            next();
            if (c == 1)
                req_valid_i[0] = 1'b0;
            if (c == 18)
                req_valid_i[1] = 1'b0;
            mid();
        end
        next();
        rst = 1'b1;
        mid();
        chk("abort limb8 live", CW'(mm_limb_valid_o), 1);
        next();
        rst = 1'b0;
        mid();
        chk("abort limb_valid", CW'(mm_limb_valid_o), 0);
        chk("abort start", CW'(mm_start_o), 0);
        chk("abort b_limb", CW'(mm_b_limb_o), 0);
        chk("abort mm_a", CW'(mm_a_o), 0);
        chk("abort rsp_valid", CW'(rsp_valid_o), 0);
        chk("abort rsp_data", rsp_data_o, 0);
        chk("abort err", CW'(err_o), 0);
        any_rsp = 0;
        got = 0;
        for (int t = 0; t < 60 && !got; t++) begin
            next();
            mid();
            any_rsp |= |rsp_valid_o;
            got = err_o;
        end
        chk("late err", CW'(err_o), 1);
        chk("late no rsp", CW'(any_rsp), 0);
        do_reset();
        mid();
        chk("err cleared", CW'(err_o), 0);

        for (int i = 0; i < 7; i++)
            do_op(vt[i].r, vt[i].a, vt[i].b, vt[i].e,
                  $sformatf("vec%0d", i));

`ifdef QPMM_SCHED_PERF_EN
        do_reset();
        do_op(0, 272'd2, 272'd2, 272'd4, "perf0");
        do_op(1, 272'd3, 272'd3, 272'd9, "perf1");
        do_op(0, 272'd4, 272'd4, 272'd16, "perf2");
        next();
        mid();
        chk("perf ops", CW'(perf_ops_o), 3);
        chk("perf feed", CW'(perf_feed_o), 51);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
